// File: rtl/range_frame_source.sv
// Buffers up to DEPTH samples and replays them as one go/finish framed burst.
// Optional continuous replay is enabled with `define RANGE_FRAME_SRC_REPEAT_EN.
module range_frame_source #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             clear,
    input  logic             start,
    input  logic             repeat_mode,
    output logic [WIDTH-1:0] data_out,
    output logic             go,
    output logic             finish,
    output logic             busy,
    output logic             start_error,
    output logic [WIDTH-1:0] expected_range,
    output logic [7:0]       frames_sent
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FIRST, BODY} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, len_q, rd_q;
    logic [WIDTH-1:0] max_q, min_q, data_q;
    logic             go_q, fin_q, serr_q;
    logic [7:0]       frames_q;

    logic             load_acc;
    logic [CW-1:0]    eff_cnt;
    logic [PW-1:0]    wptr;
    logic             start_ok;

    assign load_ready = reset && (state_q == IDLE) && (count_q < CW'(DEPTH));
    assign load_acc   = load_valid && load_ready;
    // A load on the start edge is part of the frame it launches.
    assign eff_cnt    = count_q + {{(CW-1){1'b0}}, load_acc};
    assign wptr       = clear ? '0 : count_q[PW-1:0];
    assign start_ok   = (state_q == IDLE) && start && !clear && (eff_cnt >= CW'(2));

    assign data_out       = data_q;
    assign go             = go_q;
    assign finish         = fin_q;
    assign busy           = (state_q != IDLE);
    assign start_error    = serr_q;
    assign frames_sent    = frames_q;
    assign expected_range = (count_q < CW'(2)) ? '0 : (max_q - min_q);

`ifndef RANGE_FRAME_SRC_REPEAT_EN
    logic unused_repeat;
    assign unused_repeat = repeat_mode;
`endif

    always_ff @(posedge clock) begin
        if (load_acc) mem_q[wptr] <= load_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            len_q    <= '0;
            rd_q     <= '0;
            max_q    <= '0;
            min_q    <= '0;
            data_q   <= '0;
            go_q     <= 1'b0;
            fin_q    <= 1'b0;
            serr_q   <= 1'b0;
            frames_q <= '0;
        end else begin
            serr_q <= 1'b0;
            // Clear together with a load restarts the buffer with that sample.
            if (load_acc) begin
                count_q <= clear ? CW'(1) : count_q + CW'(1);
                if (clear || count_q == '0) begin
                    max_q <= load_data;
                    min_q <= load_data;
                end else begin
                    if (load_data > max_q) max_q <= load_data;
                    if (load_data < min_q) min_q <= load_data;
                end
            end else if (state_q == IDLE && clear) begin
                count_q <= '0;
                max_q   <= '0;
                min_q   <= '0;
            end

            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q <= FIRST;
                        go_q    <= 1'b1;
                        data_q  <= mem_q[0];
                        rd_q    <= CW'(1);
                        len_q   <= eff_cnt;
                    end else if (start && !clear) begin
                        serr_q <= 1'b1;
                    end
                end
                FIRST: begin
                    state_q <= BODY;
                    go_q    <= 1'b0;
                    data_q  <= mem_q[rd_q[PW-1:0]];
                    fin_q   <= (rd_q == len_q - CW'(1));
                    rd_q    <= rd_q + CW'(1);
                end
                BODY: begin
                    if (fin_q) begin
                        frames_q <= frames_q + 8'd1;
                        fin_q    <= 1'b0;
`ifdef RANGE_FRAME_SRC_REPEAT_EN
                        if (repeat_mode) begin
                            state_q <= FIRST;
                            go_q    <= 1'b1;
                            data_q  <= mem_q[0];
                            rd_q    <= CW'(1);
                        end else begin
                            state_q <= IDLE;
                            data_q  <= '0;
                        end
`else
                        state_q <= IDLE;
                        data_q  <= '0;
`endif
                    end else begin
                        data_q <= mem_q[rd_q[PW-1:0]];
                        fin_q  <= (rd_q == len_q - CW'(1));
                        rd_q   <= rd_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_range_frame_source.sv
// Directed bench for range_frame_source: queue-based frame model checked every
// cycle, plus literal expectations for each scenario.
module tb_range_frame_source;
    localparam int WIDTH = 10;
    localparam int DEPTH = 8;
`ifdef RANGE_FRAME_SRC_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             load_valid = 1'b0;
    logic [WIDTH-1:0] load_data = '0;
    logic             clear = 1'b0;
    logic             start = 1'b0;
    logic             repeat_mode = 1'b0;
    logic             load_ready, go, finish, busy, start_error;
    logic [WIDTH-1:0] data_out, expected_range;
    logic [7:0]       frames_sent;

    range_frame_source #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .clear(clear), .start(start), .repeat_mode(repeat_mode),
        .data_out(data_out), .go(go), .finish(finish), .busy(busy),
        .start_error(start_error), .expected_range(expected_range), .frames_sent(frames_sent)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {bit g; bit f; int d;} ent_t;
    int   mq[$];
    ent_t sched[$];
    int   m_frames = 0;
    bit   m_serr = 0;
    ent_t e, h;

    function automatic int m_range();
        int mx, mn;
        if (mq.size() < 2) return 0;
        mx = mq[0]; mn = mq[0];
        foreach (mq[i]) begin
            if (mq[i] > mx) mx = mq[i];
            if (mq[i] < mn) mn = mq[i];
        end
        return mx - mn;
    endfunction

    task automatic push_frame();
        ent_t x;
        foreach (mq[i]) begin
            x.g = (i == 0);
            x.f = (i == mq.size() - 1);
            x.d = mq[i];
            sched.push_back(x);
        end
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mq.delete(); sched.delete(); m_frames = 0; m_serr = 0;
        end else begin
            m_serr = 0;
            if (sched.size() > 0) begin
                e = sched.pop_front();
                if (e.f) begin
                    m_frames = (m_frames + 1) % 256;
                    if (REP && repeat_mode) push_frame();
                end
            end else if (clear) begin
                mq.delete();
                if (load_valid) mq.push_back(int'(load_data));
            end else begin
                if (load_valid && mq.size() < DEPTH) mq.push_back(int'(load_data));
                if (start) begin
                    if (mq.size() >= 2) push_frame();
                    else m_serr = 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (sched.size() > 0) h = sched[0];
        else begin h.g = 0; h.f = 0; h.d = 0; end
        chk("m_data_out", data_out, h.d);
        chk("m_go", go, h.g);
        chk("m_finish", finish, h.f);
        chk("m_busy", busy, sched.size() > 0);
        chk("m_start_error", start_error, m_serr);
        chk("m_range", expected_range, m_range());
        chk("m_frames", frames_sent, m_frames);
        chk("m_load_ready", load_ready, reset && sched.size() == 0 && mq.size() < DEPTH);
    end

    // ---------------- stimulus helpers ----------------
    int cap[$];
    int cap_busy;
    bit cap_go_first;

    task automatic tick(); @(negedge clock); endtask
    task automatic load(input int v);
        load_valid = 1; load_data = WIDTH'(v); tick(); load_valid = 0;
    endtask
    task automatic pulse_start(); start = 1; tick(); start = 0; endtask
    task automatic do_clear(); clear = 1; tick(); clear = 0; endtask

    task automatic capture();
        cap.delete(); cap_busy = 0; cap_go_first = go;
        for (int i = 0; i < 40; i++) begin
            if (busy) begin cap_busy++; cap.push_back(int'(data_out)); end
            if (finish) begin tick(); return; end
            tick();
        end
        chk("capture_timeout", 0, 1);
    endtask

    task automatic chk_frame(input string nm, input int exp[$]);
        chk({nm, "_len"}, cap.size(), exp.size());
        chk({nm, "_go_first"}, cap_go_first, 1);
        for (int i = 0; i < exp.size() && i < cap.size(); i++)
            chk({nm, "_sample"}, cap[i], exp[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, fins;
        bit prev_fin;
        // reset state
        repeat (3) tick();
        chk("rst_go", go, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frames", frames_sent, 0);
        chk("rst_load_ready", load_ready, 0);
        #2 reset = 1;
        tick();
        chk("post_rst_load_ready", load_ready, 1);

        // basic frame and replay of retained buffer
        load(5); load(9); load(2); load(7);
        chk("basic_range", expected_range, 7);
        pulse_start();
        capture();
        chk_frame("basic", '{5, 9, 2, 7});
        chk("basic_busy_cycles", cap_busy, 4);
        chk("basic_frames", frames_sent, 1);
        chk("basic_idle_busy", busy, 0);
        pulse_start();
        capture();
        chk_frame("replay", '{5, 9, 2, 7});
        chk("replay_frames", frames_sent, 2);

        // too few samples
        do_clear();
        load(3);
        pulse_start();
        chk("few_serr", start_error, 1);
        chk("few_go", go, 0);
        chk("few_busy", busy, 0);
        tick();
        chk("few_serr_pulse", start_error, 0);
        load(6);
        pulse_start();
        capture();
        chk_frame("two", '{3, 6});
        chk("two_busy_cycles", cap_busy, 2);

        // full buffer
        do_clear();
        for (int v = 0; v < 8; v++) load(v);
        chk("full_ready", load_ready, 0);
        load(100);
        chk("full_range", expected_range, 7);
        pulse_start();
        capture();
        chk_frame("full", '{0, 1, 2, 3, 4, 5, 6, 7});

        // clear + start, then load + start
        do_clear();
        load(1); load(2); load(3); load(4);
        clear = 1; start = 1; tick(); clear = 0; start = 0;
        chk("cs_serr", start_error, 0);
        chk("cs_busy", busy, 0);
        chk("cs_range", expected_range, 0);
        load(0);
        load_valid = 1; load_data = 10'd1023; start = 1; tick();
        load_valid = 0; start = 0;
        capture();
        chk_frame("ls", '{0, 1023});
        chk("ls_range", expected_range, 1023);

        // repeat mode (ignored unless the feature is built in)
        do_clear();
        load(4); load(8); load(1);
        f0 = frames_sent; fins = 0; prev_fin = 0;
        repeat_mode = 1;
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            if (prev_fin) chk("rep_go_after_finish", go, REP);
            prev_fin = finish;
            if (finish) fins++;
            tick();
        end
        repeat_mode = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            if (finish) fins++;
            tick();
        end
        chk("rep_returns_idle", busy, 0);
        chk("rep_fin_count", fins, REP ? 5 : 1);
        chk("rep_frames", frames_sent, (f0 + fins) % 256);

        // reset mid-frame at the 3rd sample
        do_clear();
        for (int v = 10; v < 16; v++) load(v);
        pulse_start();
        tick(); tick();
        chk("mid_third_sample", data_out, 12);
        #2 reset = 0;
        #1;
        chk("mid_go", go, 0);
        chk("mid_finish", finish, 0);
        chk("mid_data", data_out, 0);
        chk("mid_busy", busy, 0);
        chk("mid_frames", frames_sent, 0);
        tick(); tick();
        #2 reset = 1;
        tick();
        chk("mid_range", expected_range, 0);
        chk("mid_ready", load_ready, 1);
        pulse_start();
        chk("mid_empty_serr", start_error, 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
